// File: rtl/dmem_if.sv
// Request/response bus for dmem_ctrl: one request in flight at a time, and each
// accepted request gets a single-cycle response after a fixed latency.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Big-endian, byte-addressed data memory controller. Byte, halfword and word
// accesses are served with a fixed latency, and misaligned or out-of-range
// requests are faulted.
module dmem_ctrl #(
   parameter int MEM_DEPTH    = 4096,
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic  clk,
   input  logic  rst_n,
   dmem_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [1:0]              r_cnt;
   logic [1:0]              w_cnt_nxt;
   logic                    r_err;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [7:0]              r_mem [MEM_DEPTH];

   logic                    w_accept;
   logic                    w_fault;
   logic                    w_rsp;
   logic [ADDR_WIDTH-1:0]   w_idx;
   logic [ADDR_WIDTH-1:0]   w_idx0;
   logic [ADDR_WIDTH-1:0]   w_idx1;
   logic [ADDR_WIDTH-1:0]   w_idx2;
   logic [ADDR_WIDTH-1:0]   w_idx3;
   logic                    w_sext;
   logic [DATA_WIDTH-1:0]   w_rdata;

   // Legal multi-byte accesses are aligned, so byte lanes are formed by forcing the low address bits.
   assign w_idx  = bus.req_addr[ADDR_WIDTH-1:0];
   assign w_idx0 = {w_idx[ADDR_WIDTH-1:2], 2'b00};
   assign w_idx1 = {w_idx[ADDR_WIDTH-1:1], 1'b1};
   assign w_idx2 = {w_idx[ADDR_WIDTH-1:2], 2'b10};
   assign w_idx3 = {w_idx[ADDR_WIDTH-1:2], 2'b11};

   assign bus.req_ready = (r_state == ST_IDLE);
   assign w_accept      = bus.req_valid && bus.req_ready;
   assign w_sext        = ~bus.req_unsigned;

   always_comb begin
      w_fault = (bus.req_addr[31:ADDR_WIDTH] != '0);
      case (bus.req_size)
         2'b01:   w_fault = w_fault | bus.req_addr[0];
         2'b10:   w_fault = w_fault | (bus.req_addr[1:0] != 2'b00);
         2'b11:   w_fault = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      w_rdata = '0;
      case (bus.req_size)
         2'b00:   w_rdata = {{24{w_sext & r_mem[w_idx][7]}}, r_mem[w_idx]};
         2'b01:   w_rdata = {{16{w_sext & r_mem[w_idx][7]}}, r_mem[w_idx], r_mem[w_idx1]};
         2'b10:   w_rdata = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
         default: ;
      endcase
   end

   // NOTE: storage has no reset, so it maps onto plain RAM and keeps committed writes across rst_n.
   always_ff @(posedge clk) begin
      if (w_accept && bus.req_write && !w_fault) begin
         case (bus.req_size)
            2'b00: r_mem[w_idx] <= bus.req_wdata[7:0];
            2'b01: begin
               r_mem[w_idx]  <= bus.req_wdata[15:8];
               r_mem[w_idx1] <= bus.req_wdata[7:0];
            end
            default: begin
               r_mem[w_idx0] <= bus.req_wdata[31:24];
               r_mem[w_idx1] <= bus.req_wdata[23:16];
               r_mem[w_idx2] <= bus.req_wdata[15:8];
               r_mem[w_idx3] <= bus.req_wdata[7:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         ST_BUSY: begin
            if (r_cnt == 2'd0) w_state_nxt = ST_IDLE;
            else               w_cnt_nxt   = r_cnt - 2'd1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The response payload is frozen at acceptance; bus changes while busy are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_err   <= w_fault;
         r_rdata <= (bus.req_write || w_fault) ? '0 : w_rdata;
      end
   end

   assign w_rsp         = (r_state == ST_BUSY) && (r_cnt == 2'd0);
   assign bus.rsp_valid = w_rsp;
   assign bus.rsp_rdata = w_rsp ? r_rdata : '0;
   assign bus.rsp_err   = w_rsp & r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_dmem_ctrl;

   localparam int MEM_DEPTH = 4096;
   localparam int LAT3      = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [7:0] ref_mem [MEM_DEPTH];

   dmem_if if1 ();
   dmem_if if3 ();

   dmem_ctrl #(.MEM_DEPTH(4096), .ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(1))
      u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   dmem_ctrl #(.MEM_DEPTH(4096), .ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(LAT3))
      u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference rules: size n bytes, aligned to n, inside MEM_DEPTH, size code 3 illegal.
   function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
      int nb;
      nb = 1 << sz;
      return (sz == 2'd3) || ((a % nb) != 0) || (a >= MEM_DEPTH);
   endfunction

   function automatic logic [31:0] ref_read(input logic [1:0] sz, input logic uns, input logic [31:0] a);
      longint v;
      int     nb;
      v  = 0;
      nb = 1 << sz;
      for (int k = 0; k < nb; k++) v = v * 256 + longint'(ref_mem[a + k]);
      if (!uns && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
      return v[31:0];
   endfunction

   task automatic ref_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int nb;
      nb = 1 << sz;
      for (int k = 0; k < nb; k++) ref_mem[a + k] = 8'(wd >> (8 * (nb - 1 - k)));
   endtask

   // One request on the latency-1 controller, checked against the reference model.
   task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          lat;
      int          wait_n;
      exp_err = ref_fault(sz, a);
      if (w || exp_err) exp_rd = 32'h0;
      else              exp_rd = ref_read(sz, uns, a);
      @(negedge clk);
      if1.req_valid    = 1'b1;
      if1.req_write    = w;
      if1.req_size     = sz;
      if1.req_unsigned = uns;
      if1.req_addr     = a;
      if1.req_wdata    = wd;
      wait_n = 0;
      while (!if1.req_ready && wait_n < 16) begin
         @(negedge clk);
         wait_n++;
      end
      check({tag, "_ready"}, 32'(if1.req_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if1.req_valid = 1'b0;
      if1.req_write = 1'b1;
      if1.req_addr  = $urandom;
      if1.req_wdata = $urandom;
      lat = 1;
      while (!if1.rsp_valid && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd1);
      check({tag, "_err"}, 32'(if1.rsp_err), 32'(exp_err));
      check({tag, "_rdata"}, if1.rsp_rdata, exp_rd);
      rd = if1.rsp_rdata;
      @(negedge clk);
      check({tag, "_pulse"}, {if1.rsp_valid, if1.rsp_err, 30'h0} | if1.rsp_rdata, 32'h0);
      if (w && !exp_err) ref_write(sz, a, wd);
   endtask

   initial begin
      logic [31:0] rd;
      logic        w;
      logic        uns;
      logic [1:0]  sz;
      logic [31:0] a;
      int          lat;

      if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_size = 2'd0;
      if1.req_unsigned = 1'b0; if1.req_addr = 32'h0; if1.req_wdata = 32'h0;
      if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_size = 2'd0;
      if3.req_unsigned = 1'b0; if3.req_addr = 32'h0; if3.req_wdata = 32'h0;

      #1;
      check("rst1_ready", 32'(if1.req_ready), 32'd1);
      check("rst1_valid", 32'(if1.rsp_valid), 32'd0);
      check("rst1_rdata", if1.rsp_rdata, 32'h0);
      check("rst1_err",   32'(if1.rsp_err), 32'd0);
      check("rst3_ready", 32'(if3.req_ready), 32'd1);
      check("rst3_valid", 32'(if3.rsp_valid), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Word write/read and sub-word extraction at 0x010
      xact("w_word10", 1'b1, 2'd2, 1'b0, 32'h010, 32'h11223344, rd);
      xact("r_word10", 1'b0, 2'd2, 1'b0, 32'h010, 32'h0, rd);
      check("r_word10_const", rd, 32'h11223344);
      xact("r_byte10", 1'b0, 2'd0, 1'b0, 32'h010, 32'h0, rd);
      check("r_byte10_const", rd, 32'h00000011);
      xact("r_byte13", 1'b0, 2'd0, 1'b0, 32'h013, 32'h0, rd);
      check("r_byte13_const", rd, 32'h00000044);
      xact("r_half12", 1'b0, 2'd1, 1'b0, 32'h012, 32'h0, rd);
      check("r_half12_const", rd, 32'h00003344);

      // Sign and zero extension at 0x020
      xact("w_word20", 1'b1, 2'd2, 1'b0, 32'h020, 32'h0, rd);
      xact("w_byte20", 1'b1, 2'd0, 1'b0, 32'h020, 32'hABCDEF80, rd);
      xact("r_sbyte20", 1'b0, 2'd0, 1'b0, 32'h020, 32'h0, rd);
      check("r_sbyte20_const", rd, 32'hFFFFFF80);
      xact("r_ubyte20", 1'b0, 2'd0, 1'b1, 32'h020, 32'h0, rd);
      check("r_ubyte20_const", rd, 32'h00000080);
      xact("w_half22", 1'b1, 2'd1, 1'b0, 32'h022, 32'h00008001, rd);
      xact("r_shalf22", 1'b0, 2'd1, 1'b0, 32'h022, 32'h0, rd);
      check("r_shalf22_const", rd, 32'hFFFF8001);

      // Faulted requests leave storage untouched
      xact("w_word00", 1'b1, 2'd2, 1'b0, 32'h000, 32'h01020304, rd);
      xact("f_rword11", 1'b0, 2'd2, 1'b0, 32'h011, 32'h0, rd);
      check("f_rword11_const", rd, 32'h0);
      xact("f_whalf21", 1'b1, 2'd1, 1'b0, 32'h021, 32'h0000BEEF, rd);
      xact("f_size3", 1'b1, 2'd3, 1'b0, 32'h010, 32'hDEADBEEF, rd);
      xact("f_oor", 1'b1, 2'd2, 1'b0, 32'h00001000, 32'hDEADBEEF, rd);
      xact("rb_word10", 1'b0, 2'd2, 1'b0, 32'h010, 32'h0, rd);
      check("rb_word10_const", rd, 32'h11223344);
      xact("rb_word20", 1'b0, 2'd2, 1'b0, 32'h020, 32'h0, rd);
      check("rb_word20_const", rd, 32'h80008001);
      xact("rb_word00", 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, rd);
      check("rb_word00_const", rd, 32'h01020304);

      // Randomized traffic in window 0x100..0x13F with occasional out-of-range addresses
      for (int i = 0; i < 16; i++) xact("init", 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), $urandom, rd);
      for (int i = 0; i < 200; i++) begin
         w   = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a   = 32'h100 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFF000) | 32'h1000;
         xact("rand", w, sz, uns, a, $urandom, rd);
      end

      // Latency-3 controller with req_valid held high: one acceptance every LAT3+1 cycles
      @(negedge clk);
      if3.req_valid = 1'b1;
      if3.req_write = 1'b1;
      if3.req_size  = 2'd2;
      if3.req_addr  = 32'h080;
      if3.req_wdata = 32'h12345678;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check($sformatf("stream_ready_%0d", k), 32'(if3.req_ready), 32'((k % (LAT3 + 1)) == LAT3));
         check($sformatf("stream_valid_%0d", k), 32'(if3.rsp_valid), 32'((k % (LAT3 + 1)) == LAT3 - 1));
      end
      if3.req_valid = 1'b0;

      // Reset while a write is pending: response dropped, stored data kept
      @(negedge clk);
      if3.req_valid = 1'b1;
      if3.req_write = 1'b1;
      if3.req_size  = 2'd2;
      if3.req_addr  = 32'h040;
      if3.req_wdata = 32'hCAFEF00D;
      check("rstw_ready", 32'(if3.req_ready), 32'd1);
      @(posedge clk);
      #1 if3.req_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 32'(if3.req_ready), 32'd1);
      check("mid_rst_valid", 32'(if3.rsp_valid), 32'd0);
      check("mid_rst_rdata", if3.rsp_rdata, 32'h0);
      check("mid_rst_err",   32'(if3.rsp_err), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("in_rst_valid_%0d", k), 32'(if3.rsp_valid), 32'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("post_rst_valid_%0d", k), 32'(if3.rsp_valid), 32'd0);
      end
      if3.req_valid = 1'b1;
      if3.req_write = 1'b0;
      if3.req_size  = 2'd2;
      if3.req_addr  = 32'h040;
      check("rb40_ready", 32'(if3.req_ready), 32'd1);
      @(posedge clk);
      #1 if3.req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!if3.rsp_valid && lat < 16);
      check("rb40_latency", 32'(lat), 32'(LAT3));
      check("rb40_rdata", if3.rsp_rdata, 32'hCAFEF00D);
      check("rb40_err", 32'(if3.rsp_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 4096, SHALL set memory size in bytes (power of two).
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL equal log2(MEM_DEPTH).
REQ-003 Parameter DATA_WIDTH, default 32, SHALL be the bus width; only 32 is supported.
REQ-004 Parameter READ_LATENCY, default 1, SHALL be cycles from acceptance to response, legal range 1..4.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 req_valid  input  1  SHALL mark a valid request.
REQ-008 req_ready  output  1  SHALL mark that a request can be accepted this cycle.
REQ-009 req_write  input  1  SHALL select write (1) or read (0).
REQ-010 req_size  input  2  SHALL select access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 req_unsigned  input  1  SHALL select zero extension (1) or sign extension (0) for byte/halfword reads.
REQ-012 req_addr  input  32  SHALL be the byte address.
REQ-013 req_wdata  input  32  SHALL be write data, right-aligned for byte/halfword.
REQ-014 rsp_valid  output  1  SHALL pulse for one cycle per accepted request.
REQ-015 rsp_rdata  output  32  SHALL carry read data while rsp_valid=1, else 0.
REQ-016 rsp_err  output  1  SHALL flag a faulted request while rsp_valid=1, else 0.

Function
REQ-017 Storage SHALL be byte-addressed, big-endian: the byte at the lowest address is the most significant.
REQ-018 FSM SHALL have states IDLE and BUSY; req_ready=1 only in IDLE.
REQ-019 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; IDLE->BUSY, latency counter loaded with READ_LATENCY-1.
REQ-020 In BUSY the counter SHALL decrement each cycle; at 0, rsp_valid=1 for exactly that cycle, then BUSY->IDLE.
REQ-021 Response SHALL therefore be visible READ_LATENCY cycles after the acceptance edge; back-to-back throughput SHALL be one request per READ_LATENCY+1 cycles.
REQ-022 Request fields SHALL be captured at acceptance; input changes during BUSY SHALL have no effect.
REQ-023 A legal write SHALL commit to storage on the acceptance edge; byte: wdata[7:0]->mem[a]; halfword: wdata[15:8]->mem[a], wdata[7:0]->mem[a+1]; word: wdata[31:24]->mem[a] .. wdata[7:0]->mem[a+3].
REQ-024 A legal read SHALL sample storage on the acceptance edge; byte returns mem[a] in [7:0]; halfword {mem[a],mem[a+1]} in [15:0]; word {mem[a]..mem[a+3]}; upper bits extended per req_unsigned.
REQ-025 Writes SHALL also produce a response; rsp_rdata=0 for writes.
REQ-026 Fault SHALL be raised when: req_size=11; halfword with addr[0]=1; word with addr[1:0]!=00; or addr[31:ADDR_WIDTH]!=0.
REQ-027 A faulted request SHALL not modify storage, SHALL return rsp_rdata=0, rsp_err=1, with normal latency.
REQ-028 Address wrap-around SHALL never occur: all multi-byte accesses are aligned and in range or faulted.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 Reset mid-operation SHALL discard the pending response; a write already committed SHALL remain.
REQ-031 Storage contents SHALL not be cleared by reset and are undefined after power-up.
REQ-032 No request SHALL be accepted on the edge where rst_n is deasserted-synchronous release is the integrator's responsibility.

Verification
REQ-033 Word write 0x11223344 @0x010, word read @0x010 (LAT=1) -> rsp_valid one cycle after acceptance, rdata 0x11223344, err 0.
REQ-034 After REQ-033, byte read @0x010 signed -> 0x00000011; byte read @0x013 -> 0x00000044; half read @0x012 -> 0x00003344.
REQ-035 Byte write 0x80 @0x020, signed byte read -> 0xFFFFFF80; unsigned -> 0x00000080; signed half write 0x8001 @0x022 read -> 0xFFFF8001.
REQ-036 Word read @0x011, half write @0x021, size 11, addr 0x00001000 -> each err=1, rdata 0, storage unchanged on read-back.
REQ-037 READ_LATENCY=3, req_valid held high continuously -> accept every 4th cycle, rsp_valid 3 cycles after each acceptance, req_ready low in between.
REQ-038 Assert rst_n=0 one cycle after accepting a write of 0xCAFEF00D @0x040 -> no rsp_valid; after release, read @0x040 -> 0xCAFEF00D.
